unibus_slave_mem: RTL and testbench



---
 rtl/unibus_pkg.sv | 22 ++
 rtl/unibus_ram.sv | 27 ++
 rtl/unibus_slave_mem.sv | 141 ++++++++++++++
 tb/tb_unibus_slave_mem.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/unibus_pkg.sv
// Shared definitions for the Unibus slave memory: cycle codes and FSM states.
package unibus_pkg;

    // Cycle type codes carried on c[1:0]
    localparam logic [1:0] C_DATI  = 2'b00;
    localparam logic [1:0] C_DATIP = 2'b01;
    localparam logic [1:0] C_DATO  = 2'b10;
    localparam logic [1:0] C_DATOB = 2'b11;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Reads (DATI/DATIP) have c[1]=0; writes (DATO/DATOB) have c[1]=1
    function automatic logic is_read(input logic [1:0] cyc);
        return ~cyc[1];
    endfunction

endpackage

// File: rtl/unibus_ram.sv
// Synchronous single-port word RAM with per-byte write enables.
// No reset; the read port is registered and only updates on a read access,
// so the last read word stays on rdata until the next read.
module unibus_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Byte-lane writes, or a registered read when no lane is enabled
    always_ff @(posedge clk) begin
        if (en) begin
            if (we[0]) mem[addr][7:0]  <= wdata[7:0];
            if (we[1]) mem[addr][15:8] <= wdata[15:8];
            if (we == 2'b00) rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/unibus_slave_mem.sv
// Unibus-style MSYN/SSYN slave memory. Accepts a cycle in its address window,
// waits WAIT_STATES clocks, performs the RAM access, then holds SSYN (and read
// data) until the master drops MSYN.
//
// Handshake: a cycle is accepted on the first IDLE posedge with msyn=1 and a
// window hit; a, c and d_in are captured there and ignored afterwards. ssyn
// rises after the access edge and stays high until msyn=0 is sampled; dropping
// msyn before the access edge aborts the cycle with no RAM side effect.
module unibus_slave_mem
    import unibus_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'o000000,
    parameter int          SIZE_WORDS  = 4096,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        msyn,
    input  logic [1:0]  c,
    input  logic [15:0] a,
    input  logic [15:0] d_in,
    output logic        ssyn,
    output logic [15:0] d_out,
    output logic        d_oe,
    output logic        locked,
    output logic [1:0]  dbg_state
);

    localparam int          AW       = $clog2(SIZE_WORDS);
    localparam logic [15:0] OFF_MASK = 16'(SIZE_WORDS * 2 - 1);

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic [AW:0] a_q;
    logic [1:0]  c_q;
    logic [15:0] d_q;
    logic        d_valid;
    logic        hit;
    logic        accept, access, done, cnt_dec;
    logic [1:0]  ram_we;
    logic [15:0] ram_rdata;

    assign hit       = (a & ~OFF_MASK) == BASE;
    assign dbg_state = state;

    // State register; reset drops ssyn immediately since ssyn decodes state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Next-state and per-edge control strobes
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        access  = 1'b0;
        done    = 1'b0;
        cnt_dec = 1'b0;
        ssyn    = 1'b0;
        case (state)
            S_IDLE: begin
                if (msyn && hit) begin
                    state_n = S_WAIT;
                    accept  = 1'b1;
                end
            end
            S_WAIT: begin
                if (!msyn) begin
                    state_n = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_n = S_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_RESP: begin
                ssyn = 1'b1;
                if (!msyn) begin
                    state_n = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Cycle capture, wait counter, read-enable and DATIP lock bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            c_q     <= C_DATI;
            d_q     <= '0;
            cnt     <= 4'd0;
            d_valid <= 1'b0;
            d_oe    <= 1'b0;
            locked  <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= a[AW:0];
                c_q <= c;
                d_q <= d_in;
                cnt <= 4'(WAIT_STATES);
            end else if (cnt_dec) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                d_oe   <= is_read(c_q);
                locked <= (c_q == C_DATIP);
                if (is_read(c_q)) d_valid <= 1'b1;
            end
            if (done) d_oe <= 1'b0;
        end
    end

    // DATOB lanes come straight from d_in, so the write data needs no steering
    always_comb begin
        ram_we = 2'b00;
        case (c_q)
            C_DATO:  ram_we = 2'b11;
            C_DATOB: ram_we = a_q[0] ? 2'b10 : 2'b01;
            default: ram_we = 2'b00;
        endcase
    end

    unibus_ram #(
        .DEPTH (SIZE_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (access),
        .we    (ram_we),
        .addr  (a_q[AW:1]),
        .wdata (d_q),
        .rdata (ram_rdata)
    );

    // RAM output has no reset, so d_out reads 0 until the first read after reset
    assign d_out = d_valid ? ram_rdata : 16'h0000;

endmodule

// File: tb/tb_unibus_slave_mem.sv
// Bench for unibus_slave_mem: two instances (WAIT_STATES=1 and 3) share one
// master; a transaction-level model predicts ssyn/d_oe/d_out/locked each cycle.
module tb_unibus_slave_mem;
    import unibus_pkg::*;

    localparam int TB_BASE = 0;
    localparam int TB_SIZE = 4096;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        msyn = 1'b0;
    logic [1:0]  c = 2'b00;
    logic [15:0] a = 16'h0000;
    logic [15:0] d_in = 16'h0000;

    logic        ssyn1, d_oe1, locked1;
    logic [15:0] d_out1;
    logic [1:0]  st1;
    logic        ssyn3, d_oe3, locked3;
    logic [15:0] d_out3;
    logic [1:0]  st3;

    unibus_slave_mem #(.BASE(16'o000000), .SIZE_WORDS(4096), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .msyn(msyn), .c(c), .a(a), .d_in(d_in),
        .ssyn(ssyn1), .d_out(d_out1), .d_oe(d_oe1), .locked(locked1), .dbg_state(st1)
    );

    unibus_slave_mem #(.BASE(16'o000000), .SIZE_WORDS(4096), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .msyn(msyn), .c(c), .a(a), .d_in(d_in),
        .ssyn(ssyn3), .d_out(d_out3), .d_oe(d_oe3), .locked(locked3), .dbg_state(st3)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic all_done = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %o, expected %o (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Each slave: idle until a hit with msyn=1, access exactly WAIT_STATES+1
    // edges later unless msyn fell first, respond until msyn is seen low.
    int          ws_of [2] = '{1, 3};
    logic        busy  [2] = '{1'b0, 1'b0};
    logic        resp  [2] = '{1'b0, 1'b0};
    int          acc_edge [2] = '{0, 0};
    logic [15:0] la [2];
    logic [1:0]  lc [2];
    logic [15:0] ld [2];
    logic [15:0] m_dout [2] = '{16'h0, 16'h0};
    logic        m_doe  [2] = '{1'b0, 1'b0};
    logic        m_lock [2] = '{1'b0, 1'b0};
    logic [15:0] mem [int];
    int          edge_no = 0;
    int          mkey;
    logic [15:0] mword;

    function automatic logic in_window(input logic [15:0] addr);
        return (int'(addr) >= TB_BASE) && (int'(addr) < TB_BASE + 2 * TB_SIZE);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    busy[i] = 1'b0; resp[i] = 1'b0;
                    m_doe[i] = 1'b0; m_lock[i] = 1'b0; m_dout[i] = 16'h0;
                end
            end else begin
                edge_no++;
                for (int i = 0; i < 2; i++) begin
                    if (!busy[i]) begin
                        if (msyn && in_window(a)) begin
                            busy[i] = 1'b1; resp[i] = 1'b0; acc_edge[i] = edge_no;
                            la[i] = a; lc[i] = c; ld[i] = d_in;
                        end
                    end else if (!resp[i]) begin
                        if (!msyn) begin
                            busy[i] = 1'b0;
                        end else if (edge_no == acc_edge[i] + ws_of[i] + 1) begin
                            mkey = i * 65536 + ((int'(la[i]) - TB_BASE) / 2);
                            mword = mem.exists(mkey) ? mem[mkey] : 16'h0000;
                            case (lc[i])
                                C_DATI, C_DATIP: begin m_dout[i] = mword; m_doe[i] = 1'b1; end
                                C_DATO:          mem[mkey] = ld[i];
                                default: begin
                                    if (la[i][0]) mword[15:8] = ld[i][15:8];
                                    else          mword[7:0]  = ld[i][7:0];
                                    mem[mkey] = mword;
                                end
                            endcase
                            m_lock[i] = (lc[i] == C_DATIP);
                            resp[i] = 1'b1;
                        end
                    end else if (!msyn) begin
                        busy[i] = 1'b0; resp[i] = 1'b0; m_doe[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        while (!all_done) begin
            @(negedge clk);
            chk("ssyn_ws1",   {15'b0, ssyn1},   {15'b0, resp[0]});
            chk("d_oe_ws1",   {15'b0, d_oe1},   {15'b0, m_doe[0]});
            chk("d_out_ws1",  d_out1,           m_dout[0]);
            chk("locked_ws1", {15'b0, locked1}, {15'b0, m_lock[0]});
            chk("ssyn_ws3",   {15'b0, ssyn3},   {15'b0, resp[1]});
            chk("d_oe_ws3",   {15'b0, d_oe3},   {15'b0, m_doe[1]});
            chk("d_out_ws3",  d_out3,           m_dout[1]);
            chk("locked_ws3", {15'b0, locked3}, {15'b0, m_lock[1]});
        end
    end

    // ---------------- driver ----------------
    // Holds msyn for 'hold' sampled edges; inputs are scrambled after the
    // accept edge since the slave must use its captured copy.
    task automatic bus_cycle(input logic [1:0] cc, input logic [15:0] aa,
                             input logic [15:0] dd, input int hold);
        c = cc; a = aa; d_in = dd; msyn = 1'b1;
        @(posedge clk); #1;
        a = 16'($urandom); c = 2'($urandom); d_in = 16'($urandom);
        repeat (hold - 1) @(posedge clk);
        #1;
        msyn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ssyn",   {15'b0, ssyn1 | ssyn3}, 16'h0);
        chk("rst_d_oe",   {15'b0, d_oe1 | d_oe3}, 16'h0);
        chk("rst_locked", {15'b0, locked1 | locked3}, 16'h0);
        chk("rst_d_out",  d_out1 | d_out3, 16'h0);
        chk("rst_state",  {14'b0, st1}, {14'b0, S_IDLE});
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: write then read with latency check
        bus_cycle(C_DATO, 16'o001000, 16'o123456, 6);
        c = C_DATI; a = 16'o001000; msyn = 1'b1;
        @(posedge clk); #1;
        chk("lat1_e0", {15'b0, ssyn1}, 16'h0);
        @(posedge clk); #1;
        chk("lat1_e1", {15'b0, ssyn1}, 16'h0);
        @(posedge clk); #1;
        chk("lat1_e2", {15'b0, ssyn1}, 16'h1);
        chk("t1_d_oe", {15'b0, d_oe1}, 16'h1);
        chk("t1_d_out", d_out1, 16'o123456);
        @(posedge clk); #1;
        chk("lat3_e3", {15'b0, ssyn3}, 16'h0);
        @(posedge clk); #1;
        chk("lat3_e4", {15'b0, ssyn3}, 16'h1);
        chk("t1_d_out3", d_out3, 16'o123456);
        msyn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // 2: byte writes on both lanes
        bus_cycle(C_DATO,  16'o001002, 16'o177777, 6);
        bus_cycle(C_DATOB, 16'o001003, 16'o000400, 6);
        bus_cycle(C_DATI,  16'o001002, 16'o000000, 6);
        chk("t2_hi_lane", d_out1, 16'o000777);
        bus_cycle(C_DATO,  16'o001004, 16'o177777, 6);
        bus_cycle(C_DATOB, 16'o001004, 16'o052525, 6);
        bus_cycle(C_DATI,  16'o001004, 16'o000000, 6);
        chk("t2_lo_lane", d_out3, 16'o177525);

        // 3: out of window for 32 cycles, aliasing word must stay intact
        bus_cycle(C_DATO, 16'o010000, 16'o022222, 6);
        c = C_DATO; a = 16'o170000; d_in = 16'o033333; msyn = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            chk("oow_ssyn", {15'b0, ssyn1 | ssyn3}, 16'h0);
        end
        msyn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus_cycle(C_DATI, 16'o010000, 16'o000000, 6);
        chk("t3_unchanged", d_out1, 16'o022222);

        // 4: aborted write leaves old data
        bus_cycle(C_DATO, 16'o001000, 16'o111111, 2);
        bus_cycle(C_DATI, 16'o001002, 16'o000000, 6);
        bus_cycle(C_DATI, 16'o001000, 16'o000000, 6);
        chk("t4_abort_ws1", d_out1, 16'o123456);
        chk("t4_abort_ws3", d_out3, 16'o123456);

        // 5: DATIP lock set, then cleared by the next completed cycle
        bus_cycle(C_DATO,  16'o000000, 16'o000042, 6);
        bus_cycle(C_DATIP, 16'o000000, 16'o000000, 6);
        chk("t5_locked", {15'b0, locked1 & locked3}, 16'h1);
        chk("t5_rdata", d_out1, 16'o000042);
        bus_cycle(C_DATO, 16'o000000, 16'o000005, 6);
        chk("t5_unlocked", {15'b0, locked1 | locked3}, 16'h0);
        bus_cycle(C_DATI, 16'o000000, 16'o000000, 6);
        chk("t5_ram0", d_out1, 16'o000005);

        // 6: reset while responding
        c = C_DATIP; a = 16'o001000; msyn = 1'b1;
        for (int k = 0; k < 10 && !ssyn1; k++) begin
            @(posedge clk); #1;
        end
        chk("t6_reach_resp", {15'b0, ssyn1}, 16'h1);
        chk("t6_locked_pre", {15'b0, locked1}, 16'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_ssyn",   {15'b0, ssyn1 | ssyn3}, 16'h0);
        chk("t6_d_oe",   {15'b0, d_oe1 | d_oe3}, 16'h0);
        chk("t6_locked", {15'b0, locked1 | locked3}, 16'h0);
        chk("t6_d_out",  d_out1, 16'h0);
        msyn = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        bus_cycle(C_DATI, 16'o001000, 16'o000000, 6);
        chk("t6_ram_kept", d_out1, 16'o123456);
        chk("t6_ram_kept3", d_out3, 16'o123456);

        all_done = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
